bus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the system bus between the CPU bus masters: IF-stage fetch, MEM-stage load/store and external masters. It takes active-low bus requests from each master and returns a registered, one-hot, active-low grant. It sits in the bus block between the masters' req_/grnt_ pins and the bus master multiplexer. It also reports the current owner index, which drives that multiplexer's select.

---
 rtl/bus_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_bus_rr_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with active-low requests and registered one-hot active-low grants.
// Optional tenure limit with forced revoke is enabled by defining BUS_ARB_TENURE_LIMIT_EN.
module bus_rr_arbiter #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned OWNER_W    = 2,
    parameter int unsigned TENURE_MAX = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MASTER_NUM-1:0] m_req_,
    output logic [MASTER_NUM-1:0] m_grnt_,
    output logic [OWNER_W-1:0]    owner,
    output logic                  owner_vld,
    output logic                  arb_switch
);

    typedef enum logic [1:0] {StIdle, StOwned, StRevoke} state_t;

    if (MASTER_NUM < 2 || MASTER_NUM > (1 << OWNER_W) || TENURE_MAX < 1) begin : g_bad_param
        $error("bus_rr_arbiter: illegal parameter combination");
    end

    state_t                r_state;
    logic [MASTER_NUM-1:0] r_grnt_;
    logic [OWNER_W-1:0]    r_owner;
    logic [OWNER_W-1:0]    r_last_owner;
    logic                  r_owner_vld;
    logic                  r_switch;

    logic [MASTER_NUM-1:0] w_req;
    logic [MASTER_NUM-1:0] w_req_m;
    logic [OWNER_W-1:0]    w_base;
    logic [OWNER_W-1:0]    w_idx;
    logic [OWNER_W-1:0]    w_winner;
    logic                  w_found;
    logic                  w_owner_req;
    logic                  w_grant;

    assign w_req       = ~m_req_;
    assign w_owner_req = w_req[r_owner];
    assign w_base      = (r_state == StIdle) ? r_last_owner : r_owner;

    // Search starts after the base; outside IDLE the base (current owner) is masked off.
    always_comb begin
        w_req_m  = w_req;
        if (r_state != StIdle) begin
            w_req_m[w_base] = 1'b0;
        end
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= int'(MASTER_NUM); i++) begin
            w_idx = OWNER_W'((int'(w_base) + i) % int'(MASTER_NUM));
            if (!w_found && w_req_m[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_grant = w_found && ((r_state == StIdle) || (r_state == StRevoke) ||
                                 ((r_state == StOwned) && !w_owner_req));

`ifdef BUS_ARB_TENURE_LIMIT_EN
    localparam int unsigned TenW = $clog2(TENURE_MAX) + 1;

    logic [TenW-1:0]       r_tenure;
    logic [MASTER_NUM-1:0] w_owner_oh;
    logic                  w_others;

    assign w_owner_oh = MASTER_NUM'(1) << r_owner;
    assign w_others   = |(w_req & ~w_owner_oh);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_grnt_      <= '1;
            r_owner      <= '0;
            r_last_owner <= OWNER_W'(MASTER_NUM - 1);
            r_owner_vld  <= 1'b0;
            r_switch     <= 1'b0;
`ifdef BUS_ARB_TENURE_LIMIT_EN
            r_tenure     <= '0;
`endif
        end else begin
            r_switch <= 1'b0;
            if (w_grant) begin
                r_state      <= StOwned;
                r_grnt_      <= ~(MASTER_NUM'(1) << w_winner);
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
                r_owner_vld  <= 1'b1;
                r_switch     <= 1'b1;
`ifdef BUS_ARB_TENURE_LIMIT_EN
                r_tenure     <= '0;
`endif
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_state <= StIdle;
                    end
                    StOwned: begin
                        if (!w_owner_req) begin
                            r_state     <= StIdle;
                            r_grnt_     <= '1;
                            r_owner_vld <= 1'b0;
                        end
`ifdef BUS_ARB_TENURE_LIMIT_EN
                        // The increment that would reach TENURE_MAX revokes if anyone waits.
                        else if (w_others && (r_tenure >= TenW'(TENURE_MAX - 1))) begin
                            r_state     <= StRevoke;
                            r_grnt_     <= '1;
                            r_owner_vld <= 1'b0;
                        end else if (r_tenure != TenW'(TENURE_MAX)) begin
                            r_tenure <= r_tenure + 1'b1;
                        end
`endif
                    end
                    StRevoke: begin
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state     <= StIdle;
                        r_grnt_     <= '1;
                        r_owner_vld <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign m_grnt_    = r_grnt_;
    assign owner      = r_owner;
    assign owner_vld  = r_owner_vld;
    assign arb_switch = r_switch;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: expected grant owners are queued by stimulus and
// popped by a monitor on every arb_switch pulse; direct checks cover idle, hold and reset.
module tb_bus_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] m_req_ = 4'b1111;
    logic [3:0] m_grnt_;
    logic [1:0] owner;
    logic       owner_vld;
    logic       arb_switch;

    int checks = 0;
    int errors = 0;
    int unsigned exp_q[$];

    bus_rr_arbiter #(
        .MASTER_NUM(4),
        .OWNER_W   (2),
        .TENURE_MAX(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req_    (m_req_),
        .m_grnt_   (m_grnt_),
        .owner     (owner),
        .owner_vld (owner_vld),
        .arb_switch(arb_switch)
    );

    always #5 clk = ~clk;

    // Monitor: every new grant must match the next queued owner.
    always @(negedge clk) begin
        if (reset && arb_switch) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected: got owner %0d grnt %b, required no new grant",
                         owner, m_grnt_);
            end else begin
                int unsigned e;
                logic [3:0]  eg;
                e  = exp_q.pop_front();
                eg = ~(4'b0001 << e);
                if (owner !== 2'(e) || m_grnt_ !== eg || owner_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL grant_order: got owner %0d grnt %b vld %b, required owner %0d grnt %b vld 1",
                             owner, m_grnt_, owner_vld, e, eg);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed view: {m_grnt_, owner_vld, owner, arb_switch}
    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {m_grnt_, owner_vld, owner, arb_switch};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got grnt %b vld %b owner %0d sw %b, required grnt %b vld %b owner %0d sw %b",
                     name, got[7:4], got[3], got[2:1], got[0], exp[7:4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset release with no requests
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_after_reset", {4'b1111, 1'b0, 2'd0, 1'b0});
        end

        // 2: single master 2 request, hold 5 cycles, release
        m_req_ = 4'b1011;
        exp_q.push_back(2);
        tick();
        check("m2_grant", {4'b1011, 1'b1, 2'd2, 1'b1});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("m2_hold", {4'b1011, 1'b1, 2'd2, 1'b0});
        end
        m_req_ = 4'b1111;
        tick();
        check("m2_release", {4'b1111, 1'b0, 2'd2, 1'b0});

        // 3: all request after reset; each releases 3 cycles after its grant
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("reset_again", {4'b1111, 1'b0, 2'd0, 1'b0});
        m_req_ = 4'b0000;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        tick();
        check("all_first_m0", {4'b1110, 1'b1, 2'd0, 1'b1});
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            m_req_[k] = 1'b1;
            tick();
            if (k < 3) begin
                check("rr_backtoback",
                      {~(4'b0001 << (k + 1)), 1'b1, 2'(k + 1), 1'b1});
            end else begin
                check("rr_all_done", {4'b1111, 1'b0, 2'd3, 1'b0});
            end
        end

        // 4: master 3 owns, 0 and 2 pending -> wrap to 0, then 2
        m_req_ = 4'b0111;
        exp_q.push_back(3);
        tick();
        check("m3_grant", {4'b0111, 1'b1, 2'd3, 1'b1});
        m_req_ = 4'b0010;
        tick();
        check("m3_no_preempt", {4'b0111, 1'b1, 2'd3, 1'b0});
        m_req_ = 4'b1010;
        exp_q.push_back(0);
        tick();
        check("wrap_to_m0", {4'b1110, 1'b1, 2'd0, 1'b1});
        m_req_ = 4'b1011;
        exp_q.push_back(2);
        tick();
        check("then_m2", {4'b1011, 1'b1, 2'd2, 1'b1});
        m_req_ = 4'b1111;
        tick();
        check("wrap_idle", {4'b1111, 1'b0, 2'd2, 1'b0});

        // 5: asynchronous reset while master 1 owns
        m_req_ = 4'b1101;
        exp_q.push_back(1);
        tick();
        check("m1_grant", {4'b1101, 1'b1, 2'd1, 1'b1});
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {4'b1111, 1'b0, 2'd0, 1'b0});
        m_req_ = 4'b1100;
        tick();
        check("reset_held", {4'b1111, 1'b0, 2'd0, 1'b0});
        reset = 1'b1;
        exp_q.push_back(0);
        tick();
        check("post_reset_m0_first", {4'b1110, 1'b1, 2'd0, 1'b1});
        m_req_ = 4'b1101;
        exp_q.push_back(1);
        tick();
        check("post_reset_m1", {4'b1101, 1'b1, 2'd1, 1'b1});
        m_req_ = 4'b1111;
        tick();
        check("post_reset_idle", {4'b1111, 1'b0, 2'd1, 1'b0});

`ifdef BUS_ARB_TENURE_LIMIT_EN
        // 6: tenure limit revokes master 0 after 16 owned cycles
        m_req_ = 4'b1110;
        exp_q.push_back(0);
        tick();
        check("ten_m0_grant", {4'b1110, 1'b1, 2'd0, 1'b1});
        m_req_ = 4'b1100;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("ten_hold", {4'b1110, 1'b1, 2'd0, 1'b0});
        end
        tick();
        check("ten_revoke", {4'b1111, 1'b0, 2'd0, 1'b0});
        exp_q.push_back(1);
        tick();
        check("ten_m1_grant", {4'b1101, 1'b1, 2'd1, 1'b1});
        m_req_ = 4'b1111;
        tick();
        check("ten_idle", {4'b1111, 1'b0, 2'd1, 1'b0});
`endif

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL grants_missing: got %0d grants outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
